// File: rtl/sum4_operand_seq.sv
// -----------------------------------------------------------------------------
// sum4_operand_seq
//   Operand sequencer and result register for a W-bit ripple adder.
//   The block takes operand A, then operand B, from one shared bus using a
//   valid/ready handshake. It presents both operands to the adder as registers.
//   One cycle later it captures {carry, sum} and holds that result until the
//   consumer acknowledges it.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   dato       in   W      shared operand bus (A first, then B)
//   dato_valid in   1      dato carries an operand this cycle
//   dato_ready out  1      an operand is accepted this cycle (CAP_A/CAP_B)
//   op_a       out  W      registered operand A, drives adder A
//   op_b       out  W      registered operand B, drives adder B
//   suma_in    in   W      adder sum output
//   carry_in   in   1      adder carry output
//   resultado  out  W+1    registered {carry_in, suma_in}
//   res_valid  out  1      resultado valid, held until res_ack
//   res_ack    in   1      consumer has taken resultado
//   n_ops      out  CNT_W  completed (acknowledged) operations, wraps
// -----------------------------------------------------------------------------
module sum4_operand_seq #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     dato,
  input  logic             dato_valid,
  output logic             dato_ready,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [W-1:0]     suma_in,
  input  logic             carry_in,
  output logic [W:0]       resultado,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [CNT_W-1:0] n_ops
);

  typedef enum logic [1:0] {
    CAP_A = 2'd0,
    CAP_B = 2'd1,
    EVAL  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_op_a;
  logic [W-1:0]     r_op_b;
  logic [W:0]       r_resultado;
  logic             r_res_valid;
  logic [CNT_W-1:0] r_n_ops;

  logic             w_ready;
  logic             w_xfer;

  // Ready is decoded from the state alone. An operand offered during
  // EVAL or HOLD is therefore refused, even when the ack arrives in the
  // same cycle. Such an operand is taken on the first cycle back in CAP_A.
  assign w_ready = (r_state == CAP_A) || (r_state == CAP_B);
  assign w_xfer  = dato_valid && w_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= CAP_A;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_resultado <= '0;
      r_res_valid <= 1'b0;
      r_n_ops     <= '0;
    end else begin
      case (r_state)
        CAP_A: begin
          if (w_xfer) begin
            r_op_a  <= dato;
            r_state <= CAP_B;
          end
        end
        CAP_B: begin
          if (w_xfer) begin
            r_op_b  <= dato;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          // The operands have been stable on the adder for one full cycle.
          r_resultado <= {carry_in, suma_in};
          r_res_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          // When ack is held high, it completes only one operation. After
          // this the FSM sits in CAP_A, where ack has no effect.
          if (res_ack) begin
            r_res_valid <= 1'b0;
            r_n_ops     <= r_n_ops + 1'b1;
            r_state     <= CAP_A;
          end
        end
        default: r_state <= CAP_A;
      endcase
    end
  end

  assign dato_ready = w_ready;
  assign op_a       = r_op_a;
  assign op_b       = r_op_b;
  assign resultado  = r_resultado;
  assign res_valid  = r_res_valid;
  assign n_ops      = r_n_ops;

endmodule

// File: tb/tb_sum4_operand_seq.sv
// -----------------------------------------------------------------------------
// tb_sum4_operand_seq
//   Directed bench for sum4_operand_seq. A combinational 4-bit adder stands in
//   for Sum4 and is fed from op_a/op_b. The expected results are hand-computed
//   constants, or A+B for the random run.
// -----------------------------------------------------------------------------
module tb_sum4_operand_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] dato;
  logic       dato_valid;
  logic       dato_ready;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic [3:0] suma_in;
  logic       carry_in;
  logic [4:0] resultado;
  logic       res_valid;
  logic       res_ack;
  logic [7:0] n_ops;

  int         n_checks;
  int         n_pass;
  logic [7:0] exp_nops;

  sum4_operand_seq #(.W(4), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dato       (dato),
    .dato_valid (dato_valid),
    .dato_ready (dato_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .suma_in    (suma_in),
    .carry_in   (carry_in),
    .resultado  (resultado),
    .res_valid  (res_valid),
    .res_ack    (res_ack),
    .n_ops      (n_ops)
  );

  // Stand-in for the Sum4 ripple adder.
  assign {carry_in, suma_in} = {1'b0, op_a} + {1'b0, op_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!dato_ready && k < 20) begin
      tick();
      k++;
    end
    chk("ready_wait", {31'd0, dato_ready}, 32'd1);
  endtask

  // Transfer A then B and run through EVAL. Returns sampled in HOLD.
  task automatic load_ab(input int a, input int b, input int exp_res);
    wait_ready();
    dato       = a[3:0];
    dato_valid = 1'b1;
    tick();                                            // A edge -> CAP_B
    chk("capb_ready", {31'd0, dato_ready}, 32'd1);
    chk("op_a", {28'd0, op_a}, a);
    dato = b[3:0];
    tick();                                            // B edge -> EVAL
    dato_valid = 1'b0;
    chk("eval_res_valid", {31'd0, res_valid}, 32'd0);
    chk("eval_ready", {31'd0, dato_ready}, 32'd0);
    chk("op_b", {28'd0, op_b}, b);
    tick();                                            // EVAL edge -> HOLD
    chk("hold_res_valid", {31'd0, res_valid}, 32'd1);
    chk("resultado", {27'd0, resultado}, exp_res);
    $display("op A=%0h B=%0h resultado=%0h n_ops=%0h", a, b, resultado, n_ops);
  endtask

  task automatic ack();
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    exp_nops = exp_nops + 8'd1;
    chk("ack_res_valid", {31'd0, res_valid}, 32'd0);
    chk("ack_n_ops", {24'd0, n_ops}, {24'd0, exp_nops});
    chk("ack_ready", {31'd0, dato_ready}, 32'd1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_resultado", {27'd0, resultado}, 32'd0);
    chk("rst_op_a", {28'd0, op_a}, 32'd0);
    chk("rst_op_b", {28'd0, op_b}, 32'd0);
    chk("rst_ready", {31'd0, dato_ready}, 32'd1);
    chk("rst_n_ops", {24'd0, n_ops}, 32'd0);
    exp_nops = 8'd0;
    #2 rst_n = 1'b1;
    tick();
  endtask

  int va [3];
  int vb [3];
  int vr [3];

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    exp_nops   = 8'd0;
    rst_n      = 1'b0;
    dato       = 4'h0;
    dato_valid = 1'b0;
    res_ack    = 1'b0;
    va = '{15, 15, 0};
    vb = '{1, 15, 0};
    vr = '{32'h10, 32'h1E, 32'h00};

    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: reset asserted in HOLD takes effect immediately.
    load_ab(3, 5, 32'h08);
    do_reset();

    // 2: basic add; the result is held until ack.
    load_ab(3, 5, 32'h08);
    repeat (2) tick();
    chk("held_res_valid", {31'd0, res_valid}, 32'd1);
    chk("held_resultado", {27'd0, resultado}, 32'h08);
    ack();

    // 3: carry boundaries.
    for (int i = 0; i < 3; i++) begin
      load_ab(va[i], vb[i], vr[i]);
      ack();
    end

    // 4: an operand offered during EVAL/HOLD is refused, then taken after ack.
    wait_ready();
    dato       = 4'h1;
    dato_valid = 1'b1;
    tick();
    dato = 4'h2;
    tick();                                            // now EVAL
    dato = 4'hA;                                       // keep valid high
    chk("t4_eval_ready", {31'd0, dato_ready}, 32'd0);
    tick();                                            // now HOLD
    chk("t4_hold_ready", {31'd0, dato_ready}, 32'd0);
    chk("t4_op_a", {28'd0, op_a}, 32'h1);
    chk("t4_op_b", {28'd0, op_b}, 32'h2);
    chk("t4_resultado", {27'd0, resultado}, 32'h03);
    tick();
    chk("t4_op_a_hold", {28'd0, op_a}, 32'h1);
    res_ack = 1'b1;
    tick();                                            // ack taken, no capture
    res_ack  = 1'b0;
    exp_nops = exp_nops + 8'd1;
    chk("t4_no_capture", {28'd0, op_a}, 32'h1);
    chk("t4_n_ops", {24'd0, n_ops}, {24'd0, exp_nops});
    tick();                                            // 4'hA captured as A
    chk("t4_capture_a", {28'd0, op_a}, 32'hA);
    dato = 4'h5;
    tick();
    dato_valid = 1'b0;
    chk("t4_op_b_new", {28'd0, op_b}, 32'h5);
    tick();
    chk("t4_res", {27'd0, resultado}, 32'h0F);
    $display("op A=a B=5 resultado=%0h n_ops=%0h", resultado, n_ops);
    ack();

    // 5: ack held high for 5 cycles counts once; ack in CAP_A does nothing.
    load_ab(7, 8, 32'h0F);
    res_ack = 1'b1;
    repeat (5) tick();
    res_ack  = 1'b0;
    exp_nops = exp_nops + 8'd1;
    chk("t5_n_ops", {24'd0, n_ops}, {24'd0, exp_nops});
    chk("t5_res_valid", {31'd0, res_valid}, 32'd0);
    chk("t5_ready", {31'd0, dato_ready}, 32'd1);
    res_ack = 1'b1;
    tick();
    res_ack = 1'b0;
    chk("t5_ack_capa_n_ops", {24'd0, n_ops}, {24'd0, exp_nops});
    chk("t5_ack_capa_valid", {31'd0, res_valid}, 32'd0);
    load_ab(2, 9, 32'h0B);                             // must start from CAP_A
    ack();

    // 6: 256 back-to-back random ops; the counter wraps back to zero.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      int a;
      int b;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      load_ab(a, b, a + b);
      ack();
    end
    chk("t6_wrap", {24'd0, n_ops}, 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
